branch_redirect_ctrl: RTL and testbench



---
 rtl/branch_redirect_ctrl_pkg.sv | 13 +
 rtl/branch_target_calc.sv | 44 ++++
 rtl/branch_redirect_ctrl.sv | 106 ++++++++++
 tb/tb_branch_redirect_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the branch redirect controller: FSM states, control-kind
// encoding and the instruction-alignment mask used by the misalign check.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, REDIR} br_state_t;

  typedef enum logic [1:0] {CK_NONE, CK_BRANCH, CK_JAL, CK_JALR} ctrl_kind_t;

  // Without compressed instructions, targets must be 4-byte aligned. Bit 0 of
  // a jalr target is already cleared, so only bit 1 can be wrong.
  localparam logic [1:0] ALIGN_MASK = 2'b10;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target datapath: resolves the control kind (jal > jalr > branch),
// the taken decision, and the redirect target for the decode instruction.
module branch_target_calc
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            dec_valid,
  input  logic            branch,
  input  logic            jal,
  input  logic            jalr,
  input  logic            cond_taken,
  input  logic [XLEN-1:0] pc_dec,
  input  logic [XLEN-1:0] branoff,
  output ctrl_kind_t      kind,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  always_comb begin
    kind = CK_NONE;
    if (dec_valid) begin
      if (jal)         kind = CK_JAL;
      else if (jalr)   kind = CK_JALR;
      else if (branch) kind = CK_BRANCH;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (kind)
      CK_JAL, CK_JALR: taken = 1'b1;
      CK_BRANCH:       taken = cond_taken;
      default:         taken = 1'b0;
    endcase
  end

  // jalr already carries the absolute rs1+imm; the others are PC-relative.
  always_comb begin
    target = pc_dec + branoff;
    if (kind == CK_JALR) target = {branoff[XLEN-1:1], 1'b0};
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: sequences IDLE/HOLD/REDIR and drives the PC
// redirect plus IF/ID stall/flush. Optional macro: BRANCH_MISALIGN_CHK_EN.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            dec_valid,
  input  logic            branch,
  input  logic            jal,
  input  logic            jalr,
  input  logic            cond_taken,
  input  logic [XLEN-1:0] pc_dec,
  input  logic [XLEN-1:0] branoff,
  input  logic            rs1_hazard,
  output logic            stall_if_id,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            flush_if_id,
  output logic            trap_misalign
);

  br_state_t       state, state_nxt;
  ctrl_kind_t      kind;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            ctrl;
  logic            needs_rs1;
  logic            capture;

  branch_target_calc #(.XLEN(XLEN)) u_calc (
    .dec_valid  (dec_valid),
    .branch     (branch),
    .jal        (jal),
    .jalr       (jalr),
    .cond_taken (cond_taken),
    .pc_dec     (pc_dec),
    .branoff    (branoff),
    .kind       (kind),
    .taken      (taken),
    .target     (target)
  );

  assign ctrl      = (kind != CK_NONE);
  assign needs_rs1 = (kind == CK_JALR) || (kind == CK_BRANCH);

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    stall_if_id = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl && needs_rs1 && rs1_hazard) begin
          state_nxt   = HOLD;
          stall_if_id = 1'b1;
        end else if (ctrl && taken) begin
          state_nxt = REDIR;
          capture   = 1'b1;
        end
      end
      HOLD: begin
        stall_if_id = rs1_hazard;
        if (!ctrl) begin
          state_nxt = IDLE;
        end else if (!rs1_hazard) begin
          state_nxt = taken ? REDIR : IDLE;
          capture   = taken;
        end
      end
      REDIR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Stall is combinational on decode inputs, so keep it quiet while in reset.
    if (!Rst) stall_if_id = 1'b0;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)         pc_target <= '0;
    else if (capture) pc_target <= target;
  end

  assign flush_if_id = (state == REDIR);

`ifdef BRANCH_MISALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)         misalign_q <= 1'b0;
    else if (capture) misalign_q <= |(target[1:0] & ALIGN_MASK);
  end

  assign pc_redirect   = (state == REDIR) && !misalign_q;
  assign trap_misalign = (state == REDIR) &&  misalign_q;
`else
  assign pc_redirect   = (state == REDIR);
  assign trap_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl; expected values are
// hand-computed. Honours BRANCH_MISALIGN_CHK_EN for the misaligned-jalr case.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        Rst;
  logic        dec_valid, branch, jal, jalr, cond_taken, rs1_hazard;
  logic [31:0] pc_dec, branoff;
  logic        stall_if_id, pc_redirect, flush_if_id, trap_misalign;
  logic [31:0] pc_target;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .Rst           (Rst),
    .dec_valid     (dec_valid),
    .branch        (branch),
    .jal           (jal),
    .jalr          (jalr),
    .cond_taken    (cond_taken),
    .pc_dec        (pc_dec),
    .branoff       (branoff),
    .rs1_hazard    (rs1_hazard),
    .stall_if_id   (stall_if_id),
    .pc_redirect   (pc_redirect),
    .pc_target     (pc_target),
    .flush_if_id   (flush_if_id),
    .trap_misalign (trap_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // kind: 0 none, 1 branch, 2 jal, 3 jalr
  task automatic drive(input int unsigned k, input logic ct, input logic [31:0] pc,
                       input logic [31:0] off, input logic hz);
    dec_valid  = (k != 0);
    branch     = (k == 1);
    jal        = (k == 2);
    jalr       = (k == 3);
    cond_taken = ct;
    pc_dec     = pc;
    branoff    = off;
    rs1_hazard = hz;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic st, input logic rd,
                            input logic fl, input logic tr, input logic [31:0] tgt);
    check({tag, ".stall"},  {31'b0, stall_if_id},   {31'b0, st});
    check({tag, ".redir"},  {31'b0, pc_redirect},   {31'b0, rd});
    check({tag, ".flush"},  {31'b0, flush_if_id},   {31'b0, fl});
    check({tag, ".trap"},   {31'b0, trap_misalign}, {31'b0, tr});
    check({tag, ".target"}, pc_target,              tgt);
  endtask

  initial begin
    Rst = 1'b0;
    drive(3, 1'b0, 32'h0, 32'h305, 1'b1);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    Rst = 1'b1;
    tick();
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // jal: redirect exactly in the following cycle
    drive(2, 1'b0, 32'h100, 32'h20, 1'b0);
    check_outs("jal.N", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_outs("jal.N1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h120);
    tick();
    check_outs("jal.N2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h120);

    // not-taken branch: nothing happens, target unchanged
    drive(1, 1'b0, 32'h200, 32'h40, 1'b0);
    check_outs("bnt.N", 1'b0, 1'b0, 1'b0, 1'b0, 32'h120);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_outs("bnt.N1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h120);
    tick();

    // jalr with two hazard cycles: stall N..M, redirect at M+2, bit 0 cleared
    drive(3, 1'b0, 32'h0, 32'h305, 1'b1);
    check_outs("jalr.h0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h120);
    tick();
    drive(3, 1'b0, 32'h0, 32'h305, 1'b1);
    check_outs("jalr.h1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h120);
    tick();
    drive(3, 1'b0, 32'h0, 32'h305, 1'b0);
    check_outs("jalr.clr", 1'b0, 1'b0, 1'b0, 1'b0, 32'h120);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_outs("jalr.redir", 1'b0, 1'b1, 1'b1, 1'b0, 32'h304);
    tick();
    check_outs("jalr.after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h304);

    // taken branch target wraps modulo 2^32
    drive(1, 1'b1, 32'hFFFF_FFF0, 32'h20, 1'b0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_outs("wrap", 1'b0, 1'b1, 1'b1, 1'b0, 32'h10);
    tick();

    // jal then taken branch next cycle: branch is flushed, single redirect
    drive(2, 1'b0, 32'h1000, 32'h40, 1'b0);
    tick();
    drive(1, 1'b1, 32'h2000, 32'h8, 1'b0);
    check_outs("b2b.r1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h1040);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_outs("b2b.r2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h1040);
    tick();
    check_outs("b2b.r3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h1040);

    // hazard hold abandoned when dec_valid drops
    drive(1, 1'b1, 32'h3000, 32'h10, 1'b1);
    check_outs("drop.h", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1040);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check_outs("drop.idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h1040);

    // reset asserted during REDIR clears everything immediately
    drive(2, 1'b0, 32'h500, 32'h10, 1'b0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_outs("rst.redir", 1'b0, 1'b1, 1'b1, 1'b0, 32'h510);
    Rst = 1'b0;
    #1;
    check_outs("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    Rst = 1'b1;
    tick();
    check_outs("rst.after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // jalr to a target with bit 1 set
    drive(3, 1'b0, 32'h0, 32'h402, 1'b0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef BRANCH_MISALIGN_CHK_EN
    check_outs("misalign", 1'b0, 1'b0, 1'b1, 1'b1, 32'h402);
`else
    check_outs("misalign", 1'b0, 1'b1, 1'b1, 1'b0, 32'h402);
`endif
    tick();
    check_outs("misalign.after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h402);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
